// File: rtl/fast_square_sweep_ctrl.sv
// Sweep controller for the fast-square RX path: steps the synthesiser,
// waits for PLL lock and settle, then gates the recorder per step.
module fast_square_sweep_ctrl #(
   parameter int NUM_FREQ_STEPS = 14,
   parameter int RECORD_TICKS   = 15000,
   parameter int SETTLE_TICKS   = 64,
   parameter int LOCK_TIMEOUT   = 65535,
   parameter int PULSE_TICKS    = 4,
   parameter int CNT_W          = 16,
   parameter int STEP_W         = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              continuous,
   input  logic              clear_status,
   input  logic              pll_locked,
   output logic              freq_step_reset_out,
   output logic              freq_step_out,
   output logic              rx_reset,
   output logic              rx_next,
   output logic              rx_record,
   output logic [STEP_W-1:0] step_index,
   output logic [15:0]       sweep_count,
   output logic              lock_error,
   output logic              busy
);

   typedef enum logic [2:0] {
      IDLE, FREQ_RESET, WAIT_LOCK, SETTLE,
      RECORD, STEP, PULSE, DONE
   } state_t;

   localparam logic [CNT_W-1:0] PULSE_END  = CNT_W'(PULSE_TICKS - 1);
   localparam logic [CNT_W-1:0] LOCK_END   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_TICKS - 1);
   localparam logic [CNT_W-1:0] REC_END    = CNT_W'(RECORD_TICKS - 1);
   localparam logic [STEP_W-1:0] LAST_IDX  = STEP_W'(NUM_FREQ_STEPS - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] timer, timer_nxt;
   logic             sync1, lock_s;
   logic             err_set, idx_clr, idx_inc, sweep_inc;
   logic             last_step;

   assign last_step = (step_index == LAST_IDX);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1  <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         sync1  <= pll_locked;
         lock_s <= sync1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = '0;
      err_set   = 1'b0;
      idx_clr   = 1'b0;
      idx_inc   = 1'b0;
      sweep_inc = 1'b0;
      if (!enable && state != IDLE) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (enable) state_nxt = FREQ_RESET;
            end
            FREQ_RESET: begin
               idx_clr = 1'b1;
               if (timer == PULSE_END) state_nxt = WAIT_LOCK;
               else timer_nxt = timer + CNT_W'(1);
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_nxt = SETTLE;
               end else if (timer == LOCK_END) begin
                  err_set   = 1'b1;
                  state_nxt = STEP;
               end else begin
                  timer_nxt = timer + CNT_W'(1);
               end
            end
            SETTLE: begin
               if (!lock_s) state_nxt = WAIT_LOCK;
               else if (timer == SETTLE_END) state_nxt = RECORD;
               else timer_nxt = timer + CNT_W'(1);
            end
            RECORD: begin
               // lock loss is flagged but the capture runs to length
               err_set = !lock_s;
               if (timer == REC_END) state_nxt = STEP;
               else timer_nxt = timer + CNT_W'(1);
            end
            STEP: begin
               if (last_step) begin
                  sweep_inc = 1'b1;
                  state_nxt = continuous ? FREQ_RESET : DONE;
               end else begin
                  idx_inc   = 1'b1;
                  state_nxt = PULSE;
               end
            end
            PULSE: begin
               if (timer == PULSE_END) state_nxt = WAIT_LOCK;
               else timer_nxt = timer + CNT_W'(1);
            end
            DONE: state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         step_index  <= '0;
         sweep_count <= '0;
         lock_error  <= 1'b0;
      end else begin
         if (idx_clr) step_index <= '0;
         else if (idx_inc) step_index <= step_index + STEP_W'(1);
         if (sweep_inc) sweep_count <= sweep_count + 16'd1;
         if (err_set) lock_error <= 1'b1;
         else if (clear_status) lock_error <= 1'b0;
      end
   end

   // outputs drop on the same edge that aborts the sweep
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         freq_step_reset_out <= 1'b0;
         rx_reset            <= 1'b0;
         freq_step_out       <= 1'b0;
         rx_next             <= 1'b0;
         rx_record           <= 1'b0;
         busy                <= 1'b0;
      end else begin
         freq_step_reset_out <= enable && state == FREQ_RESET;
         rx_reset            <= enable && state == FREQ_RESET;
         freq_step_out       <= enable && state == PULSE;
         rx_next             <= enable && state == STEP;
         rx_record           <= enable && state == RECORD;
         busy                <= enable && state != IDLE && state != DONE;
      end
   end

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Directed bench for fast_square_sweep_ctrl with a small configuration:
// 3 steps, 10-cycle record, 4-cycle settle, 2-cycle pulses, 20-cycle timeout.
module tb_fast_square_sweep_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        continuous = 1'b0;
   logic        clear_status = 1'b0;
   logic        pll_locked = 1'b0;
   logic        freq_step_reset_out, freq_step_out, rx_reset;
   logic        rx_next, rx_record, lock_error, busy;
   logic [7:0]  step_index;
   logic [15:0] sweep_count;

   fast_square_sweep_ctrl #(
      .NUM_FREQ_STEPS(3), .RECORD_TICKS(10), .SETTLE_TICKS(4),
      .LOCK_TIMEOUT(20), .PULSE_TICKS(2), .CNT_W(16), .STEP_W(8)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .continuous(continuous), .clear_status(clear_status),
      .pll_locked(pll_locked),
      .freq_step_reset_out(freq_step_reset_out),
      .freq_step_out(freq_step_out), .rx_reset(rx_reset),
      .rx_next(rx_next), .rx_record(rx_record),
      .step_index(step_index), .sweep_count(sweep_count),
      .lock_error(lock_error), .busy(busy)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errs = 0;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   logic mon_clr = 1'b0;
   int rec_win, rec_cyc, nxt_cyc, nxt_rise, stp_rise, stp_cyc;
   int rst_rise, rst_cyc, rxr_cyc, busy_cyc, idx_n;
   int idx_log [16];
   logic p_rec, p_nxt, p_stp, p_rst;

   always @(negedge clock) begin
      if (mon_clr) begin
         rec_win <= 0; rec_cyc <= 0; nxt_cyc <= 0; nxt_rise <= 0;
         stp_rise <= 0; stp_cyc <= 0; rst_rise <= 0; rst_cyc <= 0;
         rxr_cyc <= 0; busy_cyc <= 0; idx_n <= 0;
      end else begin
         if (rx_record && !p_rec) begin
            rec_win <= rec_win + 1;
            if (idx_n < 16) idx_log[idx_n] <= int'(step_index);
            idx_n <= idx_n + 1;
         end
         if (rx_record) rec_cyc <= rec_cyc + 1;
         if (rx_next) nxt_cyc <= nxt_cyc + 1;
         if (rx_next && !p_nxt) nxt_rise <= nxt_rise + 1;
         if (freq_step_out) stp_cyc <= stp_cyc + 1;
         if (freq_step_out && !p_stp) stp_rise <= stp_rise + 1;
         if (freq_step_reset_out) rst_cyc <= rst_cyc + 1;
         if (freq_step_reset_out && !p_rst) rst_rise <= rst_rise + 1;
         if (rx_reset) rxr_cyc <= rxr_cyc + 1;
         if (busy) busy_cyc <= busy_cyc + 1;
      end
      p_rec <= rx_record;
      p_nxt <= rx_next;
      p_stp <= freq_step_out;
      p_rst <= freq_step_reset_out;
   end

   task automatic restart();
      enable = 1'b0;
      repeat (3) @(negedge clock);
      @(posedge clock);
      mon_clr = 1'b1;
      @(posedge clock);
      mon_clr = 1'b0;
   endtask

   task automatic go();
      @(negedge clock);
      enable = 1'b1;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic wait_done(input string tag);
      int ok = 0;
      logic seen = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clock);
         if (busy) seen = 1'b1;
         if (seen && !busy) begin
            ok = 1;
            break;
         end
      end
      check(tag, ok, 1);
      #1;
   endtask

   task automatic wait_rec_rise(input string tag, input int n);
      int ok = 0;
      int k = 0;
      logic p = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (rx_record && !p) k++;
         p = rx_record;
         if (k >= n) begin
            ok = 1;
            break;
         end
      end
      check(tag, ok, 1);
   endtask

   initial begin
      int exp_sweeps;
      int ok;
      exp_sweeps = 0;
      repeat (3) @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      check("rst_busy", int'(busy), 0);
      check("rst_rec", int'(rx_record), 0);
      check("rst_freset", int'(freq_step_reset_out), 0);
      check("rst_sweep", int'(sweep_count), 0);
      check("rst_err", int'(lock_error), 0);

      // 1: locked single sweep
      pll_locked = 1'b1;
      restart();
      @(negedge clock);
      enable = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("t1_rise_lat0", int'(freq_step_reset_out), 0);
      @(negedge clock);
      check("t1_rise_lat1", int'(freq_step_reset_out), 1);
      wait_done("t1_done");
      exp_sweeps++;
      check("t1_rst_pulses", rst_rise, 1);
      check("t1_rst_cyc", rst_cyc, 2);
      check("t1_rxrst_cyc", rxr_cyc, 2);
      check("t1_stp_pulses", stp_rise, 2);
      check("t1_stp_cyc", stp_cyc, 4);
      check("t1_rec_win", rec_win, 3);
      check("t1_rec_cyc", rec_cyc, 30);
      check("t1_nxt_rise", nxt_rise, 3);
      check("t1_nxt_cyc", nxt_cyc, 3);
      check("t1_busy_cyc", busy_cyc, 54);
      check("t1_sweep", int'(sweep_count), exp_sweeps);
      check("t1_idx", int'(step_index), 2);
      check("t1_err", int'(lock_error), 0);
      for (int i = 0; i < 3; i++)
         check($sformatf("t1_idx_log%0d", i), idx_log[i], i);

      // 2: never locks
      pll_locked = 1'b0;
      restart();
      go();
      wait_done("t2_done");
      exp_sweeps++;
      check("t2_rec_cyc", rec_cyc, 0);
      check("t2_nxt_rise", nxt_rise, 3);
      check("t2_busy_cyc", busy_cyc, 69);
      check("t2_err", int'(lock_error), 1);
      check("t2_sweep", int'(sweep_count), exp_sweeps);
      @(negedge clock);
      clear_status = 1'b1;
      @(negedge clock);
      clear_status = 1'b0;
      check("t2_err_clr", int'(lock_error), 0);

      // 3: lock glitch in SETTLE, then in RECORD
      pll_locked = 1'b1;
      restart();
      go();
      repeat (3) @(negedge clock);
      pll_locked = 1'b0;
      @(negedge clock);
      pll_locked = 1'b1;
      check("t3_err_settle", int'(lock_error), 0);
      wait_rec_rise("t3_rec1", 1);
      repeat (3) @(negedge clock);
      pll_locked = 1'b0;
      @(negedge clock);
      pll_locked = 1'b1;
      wait_done("t3_done");
      exp_sweeps++;
      check("t3_busy_cyc", busy_cyc, 58);
      check("t3_rec_win", rec_win, 3);
      check("t3_rec_cyc", rec_cyc, 30);
      check("t3_err", int'(lock_error), 1);
      check("t3_sweep", int'(sweep_count), exp_sweeps);

      // 4: continuous, three sweeps
      restart();
      continuous = 1'b1;
      go();
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (int'(sweep_count) == exp_sweeps + 2) begin
            ok = 1;
            break;
         end
      end
      check("t4_two_sweeps", ok, 1);
      continuous = 1'b0;
      wait_done("t4_done");
      exp_sweeps += 3;
      check("t4_sweep", int'(sweep_count), exp_sweeps);
      check("t4_rst_pulses", rst_rise, 3);
      check("t4_stp_pulses", stp_rise, 6);
      check("t4_rec_win", rec_win, 9);
      check("t4_idx_n", idx_n, 9);
      for (int i = 0; i < 9; i++)
         check($sformatf("t4_idx_log%0d", i), idx_log[i], i % 3);

      // 5: abort mid-RECORD of step 1, then restart
      restart();
      go();
      wait_rec_rise("t5_rec2", 2);
      repeat (3) @(negedge clock);
      check("t5_rec_pre", int'(rx_record), 1);
      enable = 1'b0;
      @(negedge clock);
      check("t5_rec_off", int'(rx_record), 0);
      check("t5_busy_off", int'(busy), 0);
      check("t5_idx_hold", int'(step_index), 1);
      check("t5_sweep_hold", int'(sweep_count), exp_sweeps);
      @(negedge clock);
      enable = 1'b1;
      @(posedge clock);
      @(negedge clock);
      @(negedge clock);
      check("t5_freset", int'(freq_step_reset_out), 1);
      check("t5_idx0", int'(step_index), 0);
      wait_done("t5_done");
      exp_sweeps++;
      check("t5_sweep", int'(sweep_count), exp_sweeps);

      // 6: async reset during a step pulse
      restart();
      go();
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (freq_step_out) begin
            ok = 1;
            break;
         end
      end
      check("t6_pulse_seen", ok, 1);
      #2 reset = 1'b1;
      #1;
      check("t6_stp", int'(freq_step_out), 0);
      check("t6_busy", int'(busy), 0);
      check("t6_idx", int'(step_index), 0);
      check("t6_sweep", int'(sweep_count), 0);
      check("t6_err", int'(lock_error), 0);
      @(negedge clock);
      reset = 1'b0;
      enable = 1'b0;
      repeat (2) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errs);
      $finish;
   end

endmodule
